seven_seg_scan: RTL and testbench

Time-multiplexed driver for the board's four-digit, common-anode seven-segment display; it is the output stage directly downstream of the stopwatch counter. It takes four BCD digits plus per-digit decimal-point, blank and blink controls and produces the active-low `seg` and `an` buses at a fixed refresh rate. Anode guard intervals suppress ghosting, and blinking supports adjust-mode highlighting.

---
 rtl/seven_seg_scan_pkg.sv | 26 ++
 rtl/seven_seg_scan_if.sv | 14 +
 rtl/seven_seg_scan_bcd_to_seg.sv | 10 +
 rtl/seven_seg_scan.sv | 81 ++++++++
 tb/tb_seven_seg_scan.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants and BCD segment table for the four-digit seven-segment scanner.
// Segment codes are active-low gfedcba; bit 7 of the full seg bus is the decimal point.
package seven_seg_pkg;
   localparam int          NUM_DIGITS = 4;
   localparam logic [7:0]  SEG_OFF    = 8'hFF;
   localparam logic [3:0]  AN_OFF     = 4'hF;

   function automatic logic [6:0] bcd_decode(input logic [3:0] nib);
      logic [6:0] code;
      code = 7'b1111111;
      case (nib)
         4'd0: code = 7'b1000000;
         4'd1: code = 7'b1111001;
         4'd2: code = 7'b0100100;
         4'd3: code = 7'b0110000;
         4'd4: code = 7'b0011001;
         4'd5: code = 7'b0010010;
         4'd6: code = 7'b0000010;
         4'd7: code = 7'b1111000;
         4'd8: code = 7'b0000000;
         4'd9: code = 7'b0010000;
         default: code = 7'b1111111;
      endcase
      return code;
   endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus: digit/control inputs from the counter side, active-low seg/an to the board.
// master = digit source, slave = scan driver.
interface seven_seg_scan_if;
   import seven_seg_pkg::*;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_en;
   logic [NUM_DIGITS-1:0]   blank;
   logic [NUM_DIGITS-1:0]   blink_en;
   logic [7:0]              seg;
   logic [NUM_DIGITS-1:0]   an;

   modport master (output digits, dp_en, blank, blink_en, input seg, an);
   modport slave  (input digits, dp_en, blank, blink_en, output seg, an);
endinterface

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD nibble to active-low gfedcba decoder; codes 10-15 are dark.
// Zero latency, no flow control.
module bcd_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   assign seg_o = bcd_decode(nib_i);
endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit time-multiplexed seven-segment driver with anode guard and per-digit blink.
// Registered outputs, one cycle from inputs; free-running, no backpressure.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 2,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic              clk,
   input  logic              rst,
   seven_seg_scan_if.slave   disp
);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             phase_q, phase_d;
   logic [7:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic [3:0] nib;
   logic [6:0] seg7;
   logic       dark;

   assign nib  = disp.digits[{idx_q, 2'b00} +: 4];
   assign dark = disp.blank[idx_q] | (disp.blink_en[idx_q] & ~phase_q);

   bcd_to_seg u_dec (
      .nib_i (nib),
      .seg_o (seg7)
   );

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      blk_d   = blk_q + BLK_W'(1);
      phase_d = phase_q;
      an_d    = AN_OFF;
      seg_d   = SEG_OFF;
      // Slot wrap and blink wrap are independent and may coincide.
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
      if (blk_q == BLK_LAST) begin
         blk_d   = '0;
         phase_d = ~phase_q;
      end
      if ((cnt_q >= GUARD_C) && !dark) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = {~disp.dp_en[idx_q], seg7};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         blk_q   <= '0;
         phase_q <= 1'b1;
         seg_q   <= SEG_OFF;
         an_q    <= AN_OFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         blk_q   <= blk_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign disp.seg = seg_q;
   assign disp.an  = an_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed scenarios then random inputs, checked against a
// cycle-count reference model of the display timing.
module tb_seven_seg_scan;
   import seven_seg_pkg::*;

   localparam int REFRESH_DIV = 8;
   localparam int GUARD       = 2;
   localparam int BLINK_DIV   = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   k        = 0;   // cycles elapsed since reset release, as seen before the next edge

   logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                               7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

   seven_seg_scan_if ifc ();

   seven_seg_scan #(
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD       (GUARD),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .disp (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic model(input int kk, output logic [7:0] es, output logic [3:0] ea);
      int  pos, digit, nibv;
      bit  visible, dark;
      pos     = kk % REFRESH_DIV;
      digit   = (kk / REFRESH_DIV) % 4;
      visible = ((kk / BLINK_DIV) % 2) == 0;
      dark    = ifc.blank[digit] || (ifc.blink_en[digit] && !visible);
      nibv    = (ifc.digits >> (4 * digit)) & 15;
      if (pos < GUARD || dark) begin
         es = 8'hFF;
         ea = 4'hF;
      end else begin
         ea = 4'hF;
         ea[digit] = 1'b0;
         es = {~ifc.dp_en[digit], segtab[nibv]};
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s at k=%0d: observed %b expected %b", tag, k, obs, exp);
      end
   endtask

   task automatic step();
      logic [7:0] es;
      logic [3:0] ea;
      if (rst) begin
         es = 8'hFF;
         ea = 4'hF;
      end else begin
         model(k, es, ea);
      end
      @(posedge clk);
      #1;
      chk("seg", ifc.seg, es);
      chk("an", {4'b0, ifc.an}, {4'b0, ea});
      chk("one_anode", {7'b0, ($countones(~ifc.an) <= 1)}, 8'd1);
      k = rst ? 0 : k + 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      ifc.digits   = 16'h1234;
      ifc.dp_en    = 4'b0000;
      ifc.blank    = 4'b0000;
      ifc.blink_en = 4'b0000;

      // Reset held for three cycles, then two plain frames
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(2);
      // Third edge after release must show digit 0
      step();
      chk("first_lit_an", {4'b0, ifc.an}, 8'b0000_1110);
      run(64);

      ifc.dp_en = 4'b0001;
      run(32);

      ifc.dp_en  = 4'b0000;
      ifc.digits = 16'hA234;
      ifc.blank  = 4'b0100;
      run(32);

      // Blink window across several phases, from a fresh reset
      ifc.digits = 16'h5678;
      ifc.blank  = 4'b0000;
      ifc.blink_en = 4'b0010;
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(200);

      // Reset mid-slot while digit 2 is being driven
      ifc.blink_en = 4'b0000;
      ifc.dp_en    = 4'b1010;
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(20);
      chk("idx2_an", {4'b0, ifc.an}, 8'b0000_1011);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(40);

      // Random inputs changing occasionally, including mid-slot
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(7) == 0) ifc.digits   = 16'($urandom);
         if ($urandom_range(15) == 0) ifc.dp_en   = 4'($urandom);
         if ($urandom_range(15) == 0) ifc.blank   = 4'($urandom & $urandom);
         if ($urandom_range(15) == 0) ifc.blink_en = 4'($urandom);
         if ($urandom_range(299) == 0) rst = 1'b1;
         step();
         rst = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
